uart_rx_param: RTL and testbench

Parametrised UART receiver: the next-generation serial receive block for the UART subsystem. Supports configurable clock/baud ratio, 5–9 data bits and none/odd/even parity. Validates the start bit, checks parity and stop bit, and presents each received word with error qualifiers as a one-cycle strobe to the downstream FIFO or loopback logic.

---
 rtl/uart_rx_param.sv | 153 +++++++++++++++
 tb/tb_uart_rx_param.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : uart_rx_param
// Description : Parametrised UART receiver (5..9 data bits, none/odd/even
//               parity). Optional 3-sample majority vote: UART_RX_MAJ3_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_param #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD      = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0
) (
    input  logic                 sclk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] po_data,
    output logic                 po_flag,
    output logic                 parity_err,
    output logic                 frame_err
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int HALF     = BAUD_DIV / 2;
    localparam int CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    localparam logic [CNT_W-1:0] C_DIV_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [3:0]       C_LAST_BIT = 4'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_PAR   = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    state_t               r_state;
    logic                 r_rx1;
    logic                 r_rx2;
    logic                 r_rx3;
    logic [CNT_W-1:0]     r_cnt_baud;
    logic [3:0]           r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_err;

    logic                 w_start_edge;
    logic                 w_decide;
    logic                 w_sample;
    logic                 w_par_exp;

    assign w_start_edge = r_rx3 & ~r_rx2;
    assign w_par_exp    = (PARITY == 1) ? ~(^r_shift) : (^r_shift);

`ifdef UART_RX_MAJ3_EN
    localparam logic [CNT_W-1:0] C_HALF_M1 = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] C_HALF    = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] C_DECIDE  = CNT_W'(HALF + 1);

    logic r_maj0;
    logic r_maj1;

    // Collect the two earlier votes; the third is the live rx2 at decision time.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            r_maj0 <= 1'b1;
            r_maj1 <= 1'b1;
        end else begin
            if (r_cnt_baud == C_HALF_M1) r_maj0 <= r_rx2;
            if (r_cnt_baud == C_HALF)    r_maj1 <= r_rx2;
        end
    end

    assign w_sample = (r_maj0 & r_maj1) | (r_maj0 & r_rx2) | (r_maj1 & r_rx2);
`else
    localparam logic [CNT_W-1:0] C_DECIDE = CNT_W'(HALF);

    assign w_sample = r_rx2;
`endif

    assign w_decide = (r_cnt_baud == C_DECIDE);

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx1      <= 1'b1;
            r_rx2      <= 1'b1;
            r_rx3      <= 1'b1;
            r_state    <= S_IDLE;
            r_cnt_baud <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_par_err  <= 1'b0;
            po_data    <= '0;
            po_flag    <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            r_rx1   <= rx;
            r_rx2   <= r_rx1;
            r_rx3   <= r_rx2;
            po_flag <= 1'b0;

            if (r_state == S_IDLE) begin
                r_cnt_baud <= '0;
                if (w_start_edge) r_state <= S_START;
            end else begin
                // The baud counter free-runs across bit states of one frame.
                r_cnt_baud <= (r_cnt_baud == C_DIV_LAST) ? '0 : r_cnt_baud + 1'b1;

                if (w_decide) begin
                    case (r_state)
                        S_START: begin
                            if (w_sample) begin
                                r_state    <= S_IDLE;
                                r_cnt_baud <= '0;
                            end else begin
                                r_state   <= S_DATA;
                                r_bit_cnt <= '0;
                                r_par_err <= 1'b0;
                            end
                        end
                        S_DATA: begin
                            r_shift   <= {w_sample, r_shift[DATA_BITS-1:1]};
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            if (r_bit_cnt == C_LAST_BIT)
                                r_state <= (PARITY != 0) ? S_PAR : S_STOP;
                        end
                        S_PAR: begin
                            r_par_err <= w_sample ^ w_par_exp;
                            r_state   <= S_STOP;
                        end
                        S_STOP: begin
                            // Leave mid-stop so the next start edge can be caught early.
                            r_state    <= S_IDLE;
                            r_cnt_baud <= '0;
                            po_data    <= r_shift;
                            parity_err <= r_par_err;
                            frame_err  <= ~w_sample;
                            po_flag    <= 1'b1;
                        end
                        default: begin
                            r_state    <= S_IDLE;
                            r_cnt_baud <= '0;
                        end
                    endcase
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_uart_rx_param
// Description : Randomised bench for uart_rx_param (8N1, 7E1, 6O1 instances)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_param;

    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 100_000;
    localparam int DIV      = CLK_FREQ / BAUD;
    localparam int HALF     = DIV / 2;
`ifdef UART_RX_MAJ3_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif

    typedef struct packed {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
        int         cyc;
    } exp_t;

    logic       sclk  = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] rx    = 3'b111;
    int         cyc   = 0;

    logic [7:0] data_a;
    logic [6:0] data_b;
    logic [5:0] data_c;
    logic       flag_a, flag_b, flag_c;
    logic       perr_a, perr_b, perr_c;
    logic       ferr_a, ferr_b, ferr_c;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];

    int n_checks = 0;
    int n_errors = 0;

    uart_rx_param #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0)) u_dut_a (
        .sclk(sclk), .rst_n(rst_n), .rx(rx[0]), .po_data(data_a),
        .po_flag(flag_a), .parity_err(perr_a), .frame_err(ferr_a));

    uart_rx_param #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(7), .PARITY(2)) u_dut_b (
        .sclk(sclk), .rst_n(rst_n), .rx(rx[1]), .po_data(data_b),
        .po_flag(flag_b), .parity_err(perr_b), .frame_err(ferr_b));

    uart_rx_param #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(6), .PARITY(1)) u_dut_c (
        .sclk(sclk), .rst_n(rst_n), .rx(rx[2]), .po_data(data_c),
        .po_flag(flag_c), .parity_err(perr_c), .frame_err(ferr_c));

    always #5 sclk = ~sclk;
    always @(posedge sclk) cyc <= cyc + 1;

    function automatic int nbits(input int d);
        return (d == 0) ? 8 : (d == 1) ? 7 : 6;
    endfunction

    function automatic int npar(input int d);
        return (d == 0) ? 0 : (d == 1) ? 2 : 1;
    endfunction

    function automatic string dname(input int d);
        return (d == 0) ? "a" : (d == 1) ? "b" : "c";
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge sclk);
            #1;
        end
    endtask

    task automatic set_rx(input int d, input logic v);
        rx[d] = v;
    endtask

    task automatic on_flag(input int d, input logic [8:0] data, input logic perr, input logic ferr);
        exp_t e;
        int   avail;
        avail = (d == 0) ? q_a.size() : (d == 1) ? q_b.size() : q_c.size();
        check($sformatf("%s_flag_expected", dname(d)), 32'(avail != 0), 32'd1);
        if (avail == 0) return;
        case (d)
            0:       e = q_a.pop_front();
            1:       e = q_b.pop_front();
            default: e = q_c.pop_front();
        endcase
        check($sformatf("%s_data", dname(d)), 32'(data), 32'(e.data));
        check($sformatf("%s_parity_err", dname(d)), 32'(perr), 32'(e.perr));
        check($sformatf("%s_frame_err", dname(d)), 32'(ferr), 32'(e.ferr));
        check($sformatf("%s_flag_cycle", dname(d)), 32'(cyc), 32'(e.cyc));
    endtask

    always @(negedge sclk) if (rst_n && flag_a) on_flag(0, 9'(data_a), perr_a, ferr_a);
    always @(negedge sclk) if (rst_n && flag_b) on_flag(1, 9'(data_b), perr_b, ferr_b);
    always @(negedge sclk) if (rst_n && flag_c) on_flag(2, 9'(data_c), perr_c, ferr_c);

    task automatic check_reset_state(input string w);
        check({w, "_data_a"}, 32'(data_a), 32'd0);
        check({w, "_data_b"}, 32'(data_b), 32'd0);
        check({w, "_data_c"}, 32'(data_c), 32'd0);
        check({w, "_flags"}, 32'({flag_a, flag_b, flag_c}), 32'd0);
        check({w, "_perr"}, 32'({perr_a, perr_b, perr_c}), 32'd0);
        check({w, "_ferr"}, 32'({ferr_a, ferr_b, ferr_c}), 32'd0);
    endtask

    // Drives one frame on line d; the expected report is derived from the
    // transmitted bits (ones count incl. parity bit, stop level, frame length).
    task automatic send_frame(input int d, input logic [8:0] data, input logic pflip,
                              input logic stop, input int glitch_k, input int abort_k);
        logic [11:0] bits;
        int          nb, n, p, ones, c;
        logic        pbit;
        exp_t        e;
        n    = nbits(d);
        p    = npar(d);
        data = data & ~(9'h1FF << n);
        ones = $countones(data);
        pbit = ((p == 2) ? ones[0] : ~ones[0]) ^ pflip;
        bits = '0;
        for (int i = 0; i < n; i++) bits[1 + i] = data[i];
        nb = n + 1;
        if (p != 0) begin
            bits[nb] = pbit;
            nb++;
        end
        bits[nb] = stop;
        nb++;
        c = cyc;
        e.data = data;
        e.ferr = ~stop;
        if (p == 0)      e.perr = 1'b0;
        else if (p == 2) e.perr = ((ones + int'(pbit)) % 2) == 1;
        else             e.perr = ((ones + int'(pbit)) % 2) == 0;
        e.cyc = c + 4 + HALF + (nb - 1) * DIV + MAJ;
        if (abort_k < 0) begin
            case (d)
                0:       q_a.push_back(e);
                1:       q_b.push_back(e);
                default: q_c.push_back(e);
            endcase
        end
        for (int k = 0; k < nb; k++) begin
            set_rx(d, bits[k]);
            for (int j = 0; j < DIV; j++) begin
                @(posedge sclk);
                #1;
                if (k == abort_k && j == HALF) begin
                    rst_n = 1'b0;
                    set_rx(d, 1'b1);
                    #1;
                    check_reset_state("midframe_reset");
                    idle(2);
                    rst_n = 1'b1;
                    idle(2);
                    return;
                end
                if (k == glitch_k && j == HALF)     set_rx(d, 1'b1);
                if (k == glitch_k && j == HALF + 1) set_rx(d, bits[k]);
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected run to complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] rd;
        logic       pf;
        logic       st;

        rst_n = 1'b0;
        rx    = 3'b111;
        idle(3);
        check_reset_state("por");
        rst_n = 1'b1;
        idle(4);

        // 8N1 0xA5
        send_frame(0, 9'hA5, 1'b0, 1'b1, -1, -1);
        idle(DIV);

        // 7E1: good then inverted parity bit
        send_frame(1, 9'h35, 1'b0, 1'b1, -1, -1);
        idle(DIV);
        send_frame(1, 9'h35, 1'b1, 1'b1, -1, -1);
        idle(DIV);

        // Stop bit low, then a clean 0x00
        send_frame(0, 9'h3C, 1'b0, 1'b0, -1, -1);
        set_rx(0, 1'b1);
        idle(2 * DIV);
        send_frame(0, 9'h00, 1'b0, 1'b1, -1, -1);
        idle(DIV);

        // Short low pulse is a false start; 0x55 must follow cleanly
        set_rx(0, 1'b0);
        idle($urandom_range(1, HALF - 2));
        set_rx(0, 1'b1);
        idle(2 * DIV);
        send_frame(0, 9'h55, 1'b0, 1'b1, -1, -1);

        // Back-to-back with a single stop bit
        send_frame(0, 9'h01, 1'b0, 1'b1, -1, -1);
        send_frame(0, 9'hFE, 1'b0, 1'b1, -1, -1);
        send_frame(0, 9'h80, 1'b0, 1'b1, -1, -1);
        idle(DIV);

        // Reset during data bit 4, then 0x77
        send_frame(0, 9'h99, 1'b0, 1'b1, -1, 5);
        idle(DIV);
        send_frame(0, 9'h77, 1'b0, 1'b1, -1, -1);
        idle(DIV);
`ifdef UART_RX_MAJ3_EN
        send_frame(0, 9'h77, 1'b0, 1'b1, 4, -1);
        idle(DIV);
`endif

        // Break: one frame with frame_err, no retrigger while low
        send_frame(0, 9'h00, 1'b0, 1'b0, -1, -1);
        idle(30 * DIV);
        set_rx(0, 1'b1);
        idle(2 * DIV);

        // Odd parity directed frames
        send_frame(2, 9'h2A, 1'b0, 1'b1, -1, -1);
        idle(DIV);
        send_frame(2, 9'h2A, 1'b1, 1'b1, -1, -1);
        idle(DIV);

        for (int i = 0; i < 8; i++) begin
            for (int d = 0; d < 3; d++) begin
                rd = 9'($urandom);
                pf = (npar(d) != 0) && ($urandom_range(0, 3) == 0);
                st = ($urandom_range(0, 5) != 0);
                send_frame(d, rd, pf, st, -1, -1);
                if (!st) begin
                    set_rx(d, 1'b1);
                    idle(DIV);
                end
                idle($urandom_range(0, DIV));
            end
        end

        idle(2 * DIV);
        check("pending_a", 32'(q_a.size()), 32'd0);
        check("pending_b", 32'(q_b.size()), 32'd0);
        check("pending_c", 32'(q_c.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
